// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared types, constants and CRC helper
// for the mtm_Alu serial front end.
package mtm_alu_pkg;

  typedef enum logic {
    BYTE_DATA = 1'b0,
    BYTE_CTL  = 1'b1
  } byte_type_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  localparam int FRAME_LEN = 11;
  localparam int CMD_LEN   = 9;

  // Eight CRC4 steps, MSB first.
  function automatic logic [3:0] crc4_byte(
    input logic [3:0] r,
    input logic [7:0] d
  );
    logic [3:0] c;
    c = r;
    for (int i = 7; i >= 0; i--) begin
      c = {c[2], c[1], c[0] ^ c[3], c[3] ^ d[i]};
    end
    return c;
  endfunction

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/mtm_alu_byte_rx.sv
// mtm_alu_byte_rx: bit-level framer, turns the sampled
// serial line into typed bytes and framing-error pulses.
module mtm_alu_byte_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       byte_valid,
  output byte_type_t byte_type,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       rx_idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_BITS,
    S_STOP
  } state_t;

  state_t     state, state_nx;
  logic       sin_q;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] sh, sh_nx;
  byte_type_t typ, typ_nx;
  logic       bv_nx, fe_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sin_q      <= 1'b1;
      cnt        <= '0;
      sh         <= '0;
      typ        <= BYTE_DATA;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      sin_q      <= sin;
      cnt        <= cnt_nx;
      sh         <= sh_nx;
      typ        <= typ_nx;
      byte_valid <= bv_nx;
      frame_err  <= fe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    typ_nx   = typ;
    bv_nx    = 1'b0;
    fe_nx    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!sin_q) state_nx = S_TYPE;
      end
      S_TYPE: begin
        typ_nx   = byte_type_t'(sin_q);
        cnt_nx   = '0;
        state_nx = S_BITS;
      end
      S_BITS: begin
        sh_nx  = {sh[6:0], sin_q};
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) state_nx = S_STOP;
      end
      S_STOP: begin
        bv_nx    = sin_q;
        fe_nx    = !sin_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign byte_type = typ;
  assign byte_data = sh;
  assign rx_idle   = (state == S_IDLE);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: assembles framed bytes into
// checked ALU commands behind a one-entry output register.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_b,
  output logic [31:0] out_a,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT + 2);

  logic       byte_valid;
  byte_type_t byte_type;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       rx_idle;

  logic [3:0]    bcnt;
  logic [3:0]    crc;
  logic [3:0]    crc_fin;
  logic [63:0]   data;
  logic [TW-1:0] idle_cnt;
  logic          tmo;
  logic          done;
  logic [2:0]    d_op;
  logic [2:0]    d_err;
  logic          accept;

  mtm_alu_byte_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .byte_valid (byte_valid),
    .byte_type  (byte_type),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .rx_idle    (rx_idle)
  );

  assign tmo = (TIMEOUT != 0) &&
               (idle_cnt > TW'(TIMEOUT));
  assign accept = out_valid && out_ready;

  always_comb begin
    done    = 1'b0;
    d_op    = '0;
    d_err   = '0;
    crc_fin = crc4_byte(crc, {1'b1, byte_data[6:4], 4'b0000});
    unique case (1'b1)
      frame_err: begin
        done  = 1'b1;
        d_err = ERR_DATA;
      end
      byte_valid && byte_type == BYTE_CTL: begin
        done = 1'b1;
        d_op = byte_data[6:4];
        if (bcnt != 4'(CMD_LEN - 1))
          d_err = ERR_DATA;
        else if (crc_fin != byte_data[3:0])
          d_err = ERR_CRC;
        else if (!op_legal(byte_data[6:4]))
          d_err = ERR_OP;
      end
      byte_valid && byte_type == BYTE_DATA &&
      bcnt == 4'(CMD_LEN - 1): begin
        done  = 1'b1;
        d_err = ERR_DATA;
      end
      default: ;
    endcase
  end

  // Command assembly; uncaptured bytes stay zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      crc      <= '0;
      data     <= '0;
      idle_cnt <= '0;
    end else begin
      if (done || tmo) begin
        bcnt <= '0;
        crc  <= '0;
        data <= '0;
      end else if (byte_valid) begin
        data[{3'd7 - bcnt[2:0], 3'b000} +: 8] <= byte_data;
        crc  <= crc4_byte(crc, byte_data);
        bcnt <= bcnt + 4'd1;
      end
      if (rx_idle && !byte_valid && bcnt != '0)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_b     <= '0;
      out_a     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= done && out_valid && !out_ready;
      if (done && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_b     <= data[63:32];
        out_a     <= data[31:0];
        out_op    <= d_op;
        out_err   <= d_err;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
